aes_ctr_engine: RTL and testbench
=================================

Name: aes_ctr_engine

Overview:
- Iterative AES-128 engine in counter (CTR) mode for CAN-SEC payload protection; successor to the fixed single-block AES control.
- Generates one keystream block per counter value (one round per clock) and XORs it with streamed 128-bit payload blocks.
- Counter width, block-count width and job length are run-time or parametrised. Valid/ready on both sides, and abort on TX/RX completion.

Parameters:
- CNT_W, 32, counter field width in the 128-bit counter block; nonce width is 128-CNT_W.
- BLK_CNT_W, 8, width of num_blocks; a job covers at most 2^BLK_CNT_W-1 blocks.

Ports:
- clk  in  1  clock.
- g_rst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; sampled in IDLE only.
- abort  in  1  synchronous job kill (tx_success/rx_success OR'd upstream).
- key  in  128  cipher key, captured on accepted start.
- nonce  in  128-CNT_W  captured on accepted start.
- cnt_init  in  CNT_W  initial counter, captured on accepted start.
- num_blocks  in  BLK_CNT_W  blocks in job, captured on accepted start.
- in_valid  in  1  payload block valid.
- in_data  in  128  payload block.
- in_ready  out  1  payload accepted when in_valid&in_ready.
- out_valid  out  1  result valid.
- out_data  out  128  in_data XOR keystream.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; all outputs 0; internal key, counter, round and block registers cleared.
- States:
  - IDLE: start=1 captures key/nonce/cnt_init/num_blocks. If num_blocks=0, go to FINISH; else go to ENC with round=0.
  - ENC: round 0 computes state = {nonce,ctr} ^ key. Rounds 1..9 run SubBytes, ShiftRows, MixColumns and AddRoundKey. Round 10 omits MixColumns. Round keys are expanded on the fly, one per cycle, from the stored key (rcon table). After round 10 the keystream is registered and the state goes to XFER. Each block takes 11 cycles from entering ENC to keystream ready.
  - XFER: in_ready=1 while the output register is empty or being drained this cycle. On in_valid&in_ready, out_data <= in_data ^ keystream and out_valid <= 1. ctr <= ctr+1 modulo 2^CNT_W; the nonce is never modified on wrap. blocks_left decrements. If blocks_left becomes 0 go to FINISH, else go to ENC round 0.
  - FINISH: wait until out_valid=0 or out_ready=1 (last result drained), then pulse done for one cycle and return to IDLE.
- out_valid holds with out_data stable until out_ready.
- in_ready is 0 in IDLE, ENC and FINISH.
- start while busy is ignored.
- abort has priority over every transition. Next cycle: IDLE, out_valid=0, in_ready=0, no done pulse, keystream register cleared. abort together with start in IDLE: the start is dropped.
- g_rst mid-job behaves like abort and also clears the key register.
- Key and inputs are not re-sampled during a job; changes mid-job have no effect.

Optional Feature:
- Macro AES_CTR_ENGINE_PASSTHRU_EN.
- Defined: adds input bypass (1 bit). When bypass is captured high on start, no encryption runs. Each XFER accept forwards in_data unchanged with the same handshake and block counting, and ENC is skipped (1 block per accept cycle). This supports plaintext CAN XL frames through the same datapath.
- Undefined: port absent; always encrypts.

Decomposition:
- Package aes_pkg:
  - S-box function.
  - rcon constant array.
  - xtime/MixColumn function.
  - AES_BLK_W=128 and AES_ROUNDS=10 constants.
  - state enum (IDLE, ENC, XFER, FINISH).
- Sub-module aes_round_comb: combinational single round with inputs state, round_key and last_round; outputs next state and next round key. The engine owns all registers and the FSM.

Test Plan:
- FIPS-197 known answer: key 000102030405060708090a0b0c0d0e0f, nonce 00112233445566778899aabb, cnt_init ccddeeff, num_blocks 1, in_data 0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, done one cycle after out_ready handshake.
- SP800-38A CTR: key 2b7e151628aed2a6abf7158809cf4f3c, nonce f0f1f2f3f4f5f6f7f8f9fafb, cnt_init fcfdfeff, num_blocks 2, plaintexts 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff. This also checks the carry into the third counter byte.
- Counter wrap: cnt_init ffffffff, num_blocks 2 -> second block counter is {nonce,00000000}; nonce unchanged.
- Backpressure: hold out_ready=0 for 20 cycles on block 1 -> out_data stable, in_ready=0, no second accept, no done until drained.
- abort asserted during ENC round 5 of a 3-block job -> next cycle busy=0, out_valid=0, no done. A new start then produces the correct first block.
- num_blocks 0 -> no in_ready, done pulse within 2 cycles of start. start while busy -> ignored, captured values unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/round constants, FSM state type,
// S-box, round-constant table and MixColumns helpers.
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_ROUNDS = 10;
  localparam logic [3:0] LAST_RND = 4'(AES_ROUNDS);

  typedef enum logic [1:0] {IDLE, ENC, XFER, FINISH} state_t;

  // Round constants for key expansion, indexed by the round being left.
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column is the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_ctr_engine_if.sv
// Payload stream interface of the CTR engine.
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high; valid never waits on ready, and once raised, valid and data
// hold unchanged until that transfer.
interface aes_ctr_engine_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic [AES_BLK_W-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_round_comb.sv
// Combinational AES-128 round plus on-the-fly expansion of the next round key.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 last_round,
  input  logic [7:0]           rcon,
  output logic [AES_BLK_W-1:0] state_next,
  output logic [AES_BLK_W-1:0] round_key_next
);

  logic [7:0]           sb [16];
  logic [7:0]           sr [16];
  logic [AES_BLK_W-1:0] shifted;
  logic [AES_BLK_W-1:0] mixed;
  logic [31:0]          w0, w1, w2, w3, rot, temp;

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  always_comb begin
    sb      = '{default: '0};
    sr      = '{default: '0};
    shifted = '0;
    mixed   = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[8*(15-i) +: 8]);
    // byte 4c+r is row r of column c; row r rotates left by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int i = 0; i < 16; i++) shifted[8*(15-i) +: 8] = sr[i];
    for (int c = 0; c < 4; c++) mixed[32*(3-c) +: 32] = mix_column(shifted[32*(3-c) +: 32]);
    state_next = (last_round ? shifted : mixed) ^ round_key;
  end

  // Key schedule step: RotWord, SubWord, rcon, then the chained XORs.
  always_comb begin
    w0   = round_key[127:96];
    w1   = round_key[95:64];
    w2   = round_key[63:32];
    w3   = round_key[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    round_key_next = {w0 ^ temp, w1 ^ w0 ^ temp, w2 ^ w1 ^ w0 ^ temp, w3 ^ w2 ^ w1 ^ w0 ^ temp};
  end

endmodule

// File: rtl/aes_ctr_engine.sv
// Iterative AES-128 CTR engine: one round per clock, keystream XORed onto
// streamed payload blocks. Optional plaintext bypass under the macro
// AES_CTR_ENGINE_PASSTHRU_EN (adds input port bypass).
module aes_ctr_engine
  import aes_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 g_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [127-CNT_W:0]   nonce,
  input  logic [CNT_W-1:0]     cnt_init,
  input  logic [BLK_CNT_W-1:0] num_blocks,
`ifdef AES_CTR_ENGINE_PASSTHRU_EN
  input  logic                 bypass,
`endif
  aes_ctr_engine_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  state_t                state_q, state_d;
  logic [AES_BLK_W-1:0]  key_q, rk_q, blk_q, ks_q, out_data_q;
  logic [127-CNT_W:0]    nonce_q;
  logic [CNT_W-1:0]      ctr_q;
  logic [BLK_CNT_W-1:0]  blocks_left_q;
  logic [3:0]            rnd_q;
  logic                  out_valid_q, done_q;
  logic                  in_ready_c, accept, capture, finish_ok;
  logic                  bypass_in, bypass_q;
  logic [7:0]            rcon_sel;
  logic [AES_BLK_W-1:0]  round_state, round_key_next;

`ifdef AES_CTR_ENGINE_PASSTHRU_EN
  assign bypass_in = bypass;
  // Job-wide bypass flag, captured with the other job parameters.
  always_ff @(posedge clk) begin
    if (g_rst) bypass_q <= 1'b0;
    else if (capture) bypass_q <= bypass;
  end
`else
  assign bypass_in = 1'b0;
  assign bypass_q  = 1'b0;
`endif

  assign rcon_sel = (rnd_q < LAST_RND) ? RCON[rnd_q] : 8'h00;

  aes_round_comb u_round (
    .state          (blk_q),
    .round_key      (rk_q),
    .last_round     (rnd_q == LAST_RND),
    .rcon           (rcon_sel),
    .state_next     (round_state),
    .round_key_next (round_key_next)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (g_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake strobes; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    finish_ok  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        capture = 1'b1;
        if (num_blocks == '0) state_d = FINISH;
        else                  state_d = bypass_in ? XFER : ENC;
      end
      ENC: if (rnd_q == LAST_RND) state_d = XFER;
      XFER: begin
        // room when the result register is empty or drains this cycle
        in_ready_c = !out_valid_q || bus.out_ready;
        accept     = in_ready_c && bus.in_valid;
        if (accept) begin
          if (blocks_left_q == BLK_CNT_W'(1)) state_d = FINISH;
          else                                state_d = bypass_q ? XFER : ENC;
        end
      end
      FINISH: if (!out_valid_q || bus.out_ready) begin
        finish_ok = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      in_ready_c = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      finish_ok  = 1'b0;
    end
  end

  // Datapath: job capture, round iteration, counter and output register.
  always_ff @(posedge clk) begin
    if (g_rst) begin
      key_q         <= '0;
      rk_q          <= '0;
      blk_q         <= '0;
      ks_q          <= '0;
      out_data_q    <= '0;
      nonce_q       <= '0;
      ctr_q         <= '0;
      blocks_left_q <= '0;
      rnd_q         <= '0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else if (abort) begin
      ks_q        <= '0;
      out_data_q  <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish_ok;
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (capture) begin
        key_q         <= key;
        rk_q          <= key;
        nonce_q       <= nonce;
        ctr_q         <= cnt_init;
        blocks_left_q <= num_blocks;
        rnd_q         <= '0;
      end
      if (state_q == ENC) begin
        // rk_q holds the key of the round being executed
        blk_q <= (rnd_q == '0) ? ({nonce_q, ctr_q} ^ rk_q) : round_state;
        rk_q  <= round_key_next;
        if (rnd_q == LAST_RND) begin
          ks_q  <= round_state;
          rnd_q <= '0;
        end else begin
          rnd_q <= rnd_q + 4'd1;
        end
      end
      if (accept) begin
        out_data_q    <= bus.in_data ^ (bypass_q ? '0 : ks_q);
        out_valid_q   <= 1'b1;
        ctr_q         <= ctr_q + CNT_W'(1);
        blocks_left_q <= blocks_left_q - BLK_CNT_W'(1);
        rk_q          <= key_q;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Directed bench for aes_ctr_engine using FIPS-197 / SP800-38A vectors.
module tb_aes_ctr_engine;
  import aes_pkg::*;

  localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [95:0]  N_FIPS  = 96'h00112233445566778899aabb;
  localparam logic [127:0] C_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [95:0]  N_SP    = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
  localparam logic [127:0] PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1     = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] CT2     = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] AES_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         g_rst, start, abort;
  logic [127:0] key;
  logic [95:0]  nonce;
  logic [31:0]  cnt_init;
  logic [7:0]   num_blocks;
  logic         busy, done;
  state_t       dbg_state;
`ifdef AES_CTR_ENGINE_PASSTHRU_EN
  logic         bypass;
`endif
  int           n_checks = 0;
  int           n_fail   = 0;
  int           lat;

  aes_ctr_engine_if bus_if ();

  aes_ctr_engine dut (
    .clk        (clk),
    .g_rst      (g_rst),
    .start      (start),
    .abort      (abort),
    .key        (key),
    .nonce      (nonce),
    .cnt_init   (cnt_init),
    .num_blocks (num_blocks),
`ifdef AES_CTR_ENGINE_PASSTHRU_EN
    .bypass     (bypass),
`endif
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [127:0] k, input logic [95:0] n,
                           input logic [31:0] c, input logic [7:0] nb);
    key = k; nonce = n; cnt_init = c; num_blocks = nb;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_in_ready(input string tag, output int cycles);
    cycles = 0;
    while (bus_if.in_ready !== 1'b1 && cycles < 100) begin
      cycle();
      cycles++;
    end
    n_checks++;
    assert (bus_if.in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: in_ready observed %b expected 1 within 100 cycles", tag, bus_if.in_ready);
    end
  endtask

  task automatic push_block(input string tag, input logic [127:0] d);
    int cyc;
    wait_in_ready(tag, cyc);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    cycle();
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    g_rst = 1'b1; start = 1'b0; abort = 1'b0;
    key = '0; nonce = '0; cnt_init = '0; num_blocks = '0;
`ifdef AES_CTR_ENGINE_PASSTHRU_EN
    bypass = 1'b0;
`endif
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.out_ready = 1'b0;
    repeat (3) cycle();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_in_ready", bus_if.in_ready, 0);
    check("rst_out_data", bus_if.out_data, 0);
    check("rst_state", dbg_state, IDLE);
    g_rst = 1'b0;
    cycle();

    // FIPS-197 known answer, single block
    start_job(K_FIPS, N_FIPS, 32'hccddeeff, 8'd1);
    check("fips_busy", busy, 1);
    check("fips_in_ready_enc", bus_if.in_ready, 0);
    wait_in_ready("fips_wait", lat);
    check("fips_latency", lat, 11);
    bus_if.in_valid = 1'b1; bus_if.in_data = '0;
    cycle();
    bus_if.in_valid = 1'b0;
    check("fips_out_valid", bus_if.out_valid, 1);
    check("fips_out_data", bus_if.out_data, C_FIPS);
    check("fips_no_early_done", done, 0);
    bus_if.out_ready = 1'b1;
    cycle();
    check("fips_done", done, 1);
    check("fips_drained", bus_if.out_valid, 0);
    check("fips_idle", busy, 0);
    cycle();
    check("fips_done_pulse", done, 0);
    bus_if.out_ready = 1'b0;

    // SP800-38A CTR, two blocks, backpressure on block 1
    start_job(K_SP, N_SP, 32'hfcfdfeff, 8'd2);
    push_block("sp_blk1", PT1);
    check("sp_ct1", bus_if.out_data, CT1);
    bus_if.in_valid = 1'b1; bus_if.in_data = PT2;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("bp_data_stable", bus_if.out_data, CT1);
      check("bp_in_ready", bus_if.in_ready, 0);
      check("bp_no_done", done, 0);
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus_if.in_ready, 1);
    cycle();
    bus_if.in_valid = 1'b0;
    check("sp_ct2_valid", bus_if.out_valid, 1);
    check("sp_ct2", bus_if.out_data, CT2);
    check("sp_no_done_yet", done, 0);
    cycle();
    check("sp_done", done, 1);

    // counter wrap: second block uses {nonce, 0}; key 0 / block 0 is known
    start_job('0, '0, 32'hffffffff, 8'd2);
    push_block("wrap_blk1", '0);
    check("wrap_blk1_valid", bus_if.out_valid, 1);
    push_block("wrap_blk2", '0);
    check("wrap_blk2", bus_if.out_data, AES_ZERO);
    cycle();
    check("wrap_done", done, 1);

    // abort during ENC round 5 of a 3-block job
    start_job(K_SP, N_SP, 32'hfcfdfeff, 8'd3);
    repeat (5) cycle();
    check("abort_in_enc", dbg_state, ENC);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", bus_if.out_valid, 0);
    check("abort_in_ready", bus_if.in_ready, 0);
    check("abort_no_done", done, 0);
    cycle();
    check("abort_no_done2", done, 0);
    start_job(K_FIPS, N_FIPS, 32'hccddeeff, 8'd1);
    push_block("post_abort", '0);
    check("post_abort_data", bus_if.out_data, C_FIPS);
    cycle();
    check("post_abort_done", done, 1);

    // zero-length job
    start_job(K_FIPS, N_FIPS, 32'h0, 8'd0);
    check("zero_busy", busy, 1);
    check("zero_in_ready", bus_if.in_ready, 0);
    cycle();
    check("zero_done", done, 1);
    check("zero_idle", busy, 0);

    // start while busy is ignored, inputs changed mid-job have no effect
    start_job(K_SP, N_SP, 32'hfcfdfeff, 8'd1);
    repeat (2) cycle();
    key = K_FIPS; nonce = N_FIPS; cnt_init = 32'hccddeeff; num_blocks = 8'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_busy", busy, 1);
    push_block("restart_blk", PT1);
    check("restart_data", bus_if.out_data, CT1);
    cycle();
    check("restart_done", done, 1);

    // abort together with start in IDLE drops the start
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);

    // reset mid-job behaves like abort
    start_job(K_FIPS, N_FIPS, 32'hccddeeff, 8'd1);
    repeat (3) cycle();
    g_rst = 1'b1;
    cycle();
    g_rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", bus_if.out_valid, 0);
    start_job(K_FIPS, N_FIPS, 32'hccddeeff, 8'd1);
    push_block("post_rst", '0);
    check("post_rst_data", bus_if.out_data, C_FIPS);
    cycle();

`ifdef AES_CTR_ENGINE_PASSTHRU_EN
    // plaintext passthrough
    bypass = 1'b1;
    start_job(K_FIPS, N_FIPS, 32'h0, 8'd2);
    bypass = 1'b0;
    check("byp_ready", bus_if.in_ready, 1);
    push_block("byp_blk1", PT1);
    check("byp_data1", bus_if.out_data, PT1);
    push_block("byp_blk2", PT2);
    check("byp_data2", bus_if.out_data, PT2);
    cycle();
    check("byp_done", done, 1);
`endif

    bus_if.out_ready = 1'b0;
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
